// File: rtl/ecc_fifo_pkg.sv
// Shared definitions for the ECC FIFO drain logic: widths and drain FSM states.
package ecc_fifo_pkg;

  localparam int unsigned ECC_DATA_W = 32;
  localparam int unsigned ECC_CODE_W = 7;
  localparam int unsigned BUF_DEPTH  = 3;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } drain_state_t;

endpackage

// File: rtl/ecc_fifo_drain_buf.sv
// Three-entry in-order output buffer; entry 0 is always the head.
module ecc_fifo_drain_buf
  import ecc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = ECC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sec,
  input  logic              wr_ded,
  input  logic              pop,
  output logic [1:0]        cnt,
  output logic [DATA_W-1:0] head_data,
  output logic              head_sec,
  output logic              head_ded
);

  localparam int unsigned EW = DATA_W + 2;

  logic [EW-1:0] mem_q [BUF_DEPTH];
  logic [EW-1:0] mem_d [BUF_DEPTH];
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic [1:0]    wr_idx;
  logic          do_pop;
  logic          do_wr;

  // Shift toward the head on pop; the write slot is taken after the shift so a
  // simultaneous write and pop keeps both order and occupancy.
  always_comb begin
    do_pop = pop && (cnt_q != 2'd0);
    do_wr  = wr_en && ((cnt_q != 2'(BUF_DEPTH)) || do_pop);
    wr_idx = cnt_q - {1'b0, do_pop};
    cnt_d  = cnt_q + {1'b0, do_wr} - {1'b0, do_pop};
    for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_pop) begin
      for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
    end
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      if (do_wr && (wr_idx == 2'(i))) mem_d[i] = {wr_data, wr_sec, wr_ded};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    cnt       = cnt_q;
    head_data = mem_q[0][EW-1:2];
    head_sec  = mem_q[0][1];
    head_ded  = mem_q[0][0];
  end

endmodule

// File: rtl/ecc_fifo_drain.sv
// Drains an ECC FIFO into a valid/ready stream, tagging/dropping errored words
// and keeping saturating SEC/DED counters with an optional halt on DED.
module ecc_fifo_drain
  import ecc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W      = ECC_DATA_W,
  parameter int unsigned CNT_W       = 16,
  parameter bit          DROP_DED    = 1'b1,
  parameter bit          HALT_ON_DED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_dout_valid,
  input  logic              fifo_sec_err,
  input  logic              fifo_ded_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_corrected,
  output logic              m_ded,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              err_irq,
  input  logic              err_clr
);

  drain_state_t state_q, state_d;
  logic         inflight_q;
  logic [1:0]   cnt;
  logic [2:0]   occ;
  logic         sec_ev;
  logic         ded_ev;
  logic         buf_wr;
  logic         buf_pop;

  // Pop decision uses only registered occupancy so m_ready never reaches fifo_rd_en.
  always_comb begin
    occ        = {1'b0, cnt} + {2'b00, inflight_q};
    fifo_rd_en = !rst && !fifo_empty && (state_q == RUN) && (occ < 3'd3);
    ded_ev     = fifo_dout_valid && fifo_ded_err;
    sec_ev     = fifo_dout_valid && fifo_sec_err && !fifo_ded_err;
    buf_wr     = fifo_dout_valid && !(DROP_DED && fifo_ded_err);
    m_valid    = (cnt != 2'd0);
    buf_pop    = m_valid && m_ready;
  end

  ecc_fifo_drain_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (buf_wr),
    .wr_data   (fifo_dout),
    .wr_sec    (fifo_sec_err && !fifo_ded_err),
    .wr_ded    (fifo_ded_err),
    .pop       (buf_pop),
    .cnt       (cnt),
    .head_data (m_data),
    .head_sec  (m_corrected),
    .head_ded  (m_ded)
  );

  // A DED arriving together with err_clr keeps the block halted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (ded_ev && HALT_ON_DED) state_d = HALTED;
      HALTED:  if (err_clr && !(ded_ev && HALT_ON_DED)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      sec_count  <= '0;
      ded_count  <= '0;
      err_irq    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      if (err_clr) begin
        sec_count <= CNT_W'(sec_ev);
        ded_count <= CNT_W'(ded_ev);
        err_irq   <= ded_ev;
      end else begin
        if (sec_ev && (sec_count != '1)) sec_count <= sec_count + 1'b1;
        if (ded_ev && (ded_count != '1)) ded_count <= ded_count + 1'b1;
        if (ded_ev) err_irq <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_fifo_drain.sv
// Bench for ecc_fifo_drain: upstream FIFO model, queue-based output scoreboard,
// directed scenarios plus randomized traffic; a second narrow-counter instance.
module tb_ecc_fifo_drain;

  typedef struct {
    logic [31:0] data;
    logic        sec;
    logic        ded;
  } word_t;

  logic        clk;
  logic        rst;
  logic        fifo_empty, fifo_rd_en, fifo_dout_valid, fifo_sec_err, fifo_ded_err;
  logic [31:0] fifo_dout, m_data;
  logic        m_valid, m_ready, m_corrected, m_ded, err_irq, err_clr;
  logic [15:0] sec_count, ded_count;

  logic        fifo_empty_2, fifo_rd_en_2, fifo_dout_valid_2, fifo_sec_err_2, fifo_ded_err_2;
  logic [31:0] fifo_dout_2, m_data_2;
  logic        m_valid_2, m_ready_2, m_corrected_2, m_ded_2, err_irq_2, err_clr_2;
  logic [1:0]  sec_count_2, ded_count_2;

  ecc_fifo_drain dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_dout_valid(fifo_dout_valid),
    .fifo_sec_err(fifo_sec_err), .fifo_ded_err(fifo_ded_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_corrected(m_corrected), .m_ded(m_ded), .sec_count(sec_count),
    .ded_count(ded_count), .err_irq(err_irq), .err_clr(err_clr)
  );

  ecc_fifo_drain #(
    .DATA_W(32), .CNT_W(2), .DROP_DED(1'b0), .HALT_ON_DED(1'b0)
  ) dut_2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_2), .fifo_rd_en(fifo_rd_en_2),
    .fifo_dout(fifo_dout_2), .fifo_dout_valid(fifo_dout_valid_2),
    .fifo_sec_err(fifo_sec_err_2), .fifo_ded_err(fifo_ded_err_2),
    .m_valid(m_valid_2), .m_ready(m_ready_2), .m_data(m_data_2),
    .m_corrected(m_corrected_2), .m_ded(m_ded_2), .sec_count(sec_count_2),
    .ded_count(ded_count_2), .err_irq(err_irq_2), .err_clr(err_clr_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t       up_q[$];
  word_t       exp_q[$];
  word_t       out_log[$];
  logic [15:0] exp_sec, exp_ded;
  logic        exp_irq, exp_halt;
  int          n_checks, n_fail, cyc, n_rd, first_rd, first_mv, out_base, rd_base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_sec = '0; exp_ded = '0; exp_irq = 1'b0; exp_halt = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic s, input logic e);
    word_t w;
    w.data = d; w.sec = s; w.ded = e;
    up_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: observe at negedge, advance model at posedge, drive at posedge+1.
  task automatic cycle();
    logic  rd, hs;
    word_t w;
    @(negedge clk);
    rd = fifo_rd_en;
    hs = (exp_q.size() != 0) && m_ready;
    check("rd_en", rd, !rst && !fifo_empty && !exp_halt && ((exp_q.size() + int'(fifo_dout_valid)) < 3));
    check("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("m_data", m_data, exp_q[0].data);
      check("m_corrected", m_corrected, exp_q[0].sec);
      check("m_ded", m_ded, exp_q[0].ded);
    end
    check("sec_count", sec_count, exp_sec);
    check("ded_count", ded_count, exp_ded);
    check("err_irq", err_irq, exp_irq);
    if (rd) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (hs) begin
      w.data = m_data; w.sec = m_corrected; w.ded = m_ded;
      out_log.push_back(w);
    end
    @(posedge clk);
    if (!rst) begin
      if (err_clr) begin
        exp_sec = '0; exp_ded = '0; exp_irq = 1'b0; exp_halt = 1'b0;
      end
      if (hs) void'(exp_q.pop_front());
      if (fifo_dout_valid) begin
        if (fifo_ded_err) begin
          exp_ded  = sat16(exp_ded);
          exp_irq  = 1'b1;
          exp_halt = 1'b1;
        end else begin
          if (fifo_sec_err) exp_sec = sat16(exp_sec);
          w.data = fifo_dout; w.sec = fifo_sec_err; w.ded = 1'b0;
          exp_q.push_back(w);
        end
      end
    end
    #1;
    cyc++;
    err_clr = 1'b0;
    fifo_dout_valid = 1'b0; fifo_sec_err = 1'b0; fifo_ded_err = 1'b0;
    if (rd && up_q.size() != 0) begin
      w = up_q.pop_front();
      fifo_dout = w.data; fifo_sec_err = w.sec; fifo_ded_err = w.ded;
      fifo_dout_valid = 1'b1;
    end
    fifo_empty = (up_q.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic mark();
    first_rd = -1; first_mv = -1;
    out_base = out_log.size();
    rd_base = n_rd;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_tags"}, {m_corrected, m_ded}, 0);
    check({tag, "_counts"}, {sec_count, ded_count}, 0);
    check({tag, "_err_irq"}, err_irq, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; n_rd = 0;
    rst = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; fifo_dout_valid = 1'b0;
    fifo_sec_err = 1'b0; fifo_ded_err = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    fifo_empty_2 = 1'b1; fifo_dout_2 = '0; fifo_dout_valid_2 = 1'b0;
    fifo_sec_err_2 = 1'b0; fifo_ded_err_2 = 1'b0; m_ready_2 = 1'b1; err_clr_2 = 1'b0;
    clear_model();
    mark();
    run(2);
    check_reset("por");
    rst = 1'b0;

    // Clean stream with latency measurement
    m_ready = 1'b1;
    mark();
    for (int i = 1; i <= 5; i++) push(32'(i * 1000), 1'b0, 1'b0);
    run(12);
    check("t1_latency", first_mv - first_rd, 2);
    check("t1_count", out_log.size() - out_base, 5);
    for (int i = 0; i < 5; i++) begin
      if (out_base + i < out_log.size()) begin
        check("t1_data", out_log[out_base+i].data, 32'(1000 * (i + 1)));
        check("t1_tags", {out_log[out_base+i].sec, out_log[out_base+i].ded}, 0);
      end
    end

    // SEC on 2000
    mark();
    push(32'd1000, 1'b0, 1'b0); push(32'd2000, 1'b1, 1'b0); push(32'd3000, 1'b0, 1'b0);
    run(10);
    check("t2_count", out_log.size() - out_base, 3);
    if (out_base + 1 < out_log.size()) begin
      check("t2_data", out_log[out_base+1].data, 2000);
      check("t2_corrected", out_log[out_base+1].sec, 1);
    end
    check("t2_sec_count", sec_count, 1);
    check("t2_err_irq", err_irq, 0);

    // DED on 4000: dropped, halts popping until err_clr
    mark();
    for (int i = 1; i <= 4; i++) push(32'(i * 1000), 1'b0, i == 4);
    run(10);
    check("t3_ded_count", ded_count, 1);
    check("t3_err_irq", err_irq, 1);
    push(32'd5000, 1'b0, 1'b0);
    run(10);
    check("t3_halt_no_rd", n_rd - rd_base, 4);
    check("t3_count", out_log.size() - out_base, 3);
    for (int i = out_base; i < out_log.size(); i++) check("t3_no_4000", out_log[i].data == 4000, 0);
    err_clr = 1'b1;
    run(8);
    check("t3_count_after_clr", out_log.size() - out_base, 4);
    check("t3_last", out_log[out_log.size()-1].data, 5000);
    check("t3_cleared", {ded_count, err_irq}, 0);

    // Backpressure: only three pops fit buffer plus flight
    m_ready = 1'b0;
    mark();
    for (int i = 1; i <= 5; i++) push(32'(i * 1000), 1'b0, 1'b0);
    run(10);
    check("t4_pops", n_rd - rd_base, 3);
    check("t4_hold", m_data, 1000);
    m_ready = 1'b1;
    run(12);
    check("t4_count", out_log.size() - out_base, 5);
    for (int i = 0; i < 5 && out_base + i < out_log.size(); i++)
      check("t4_order", out_log[out_base+i].data, 32'(1000 * (i + 1)));

    // Reset with two buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'h100 + 32'(i), 1'b0, 1'b0);
    run(3);
    check("t5_in_flight", fifo_dout_valid, 1);
    rst = 1'b1;
    clear_model();
    #1;
    check_reset("rst_async");
    run(2);
    check_reset("rst_held");
    rst = 1'b0;
    m_ready = 1'b1;
    mark();
    run(10);
    check("t5_count", out_log.size() - out_base, 2);
    if (out_base + 1 < out_log.size()) begin
      check("t5_first", out_log[out_base].data, 32'h104);
      check("t5_second", out_log[out_base+1].data, 32'h105);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      if ($urandom_range(0, 99) < 60 && up_q.size() < 8) begin
        r = $urandom_range(0, 99);
        push($urandom(), (r < 15) || (r == 99), (r < 2) || (r == 99));
      end
      m_ready = ($urandom_range(0, 99) < 70);
      err_clr = ($urandom_range(0, 99) < 2) || (exp_halt && $urandom_range(0, 9) == 0);
      cycle();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      err_clr = exp_halt;
      cycle();
    end
    check("rand_drained", m_valid, 0);
    check("rand_up_empty", up_q.size(), 0);

    // Narrow counters, forwarded DED, no halt
    for (int i = 0; i < 5; i++) begin
      fifo_dout_valid_2 = 1'b1; fifo_sec_err_2 = 1'b1; fifo_dout_2 = 32'(i);
      cycle();
    end
    fifo_dout_valid_2 = 1'b0; fifo_sec_err_2 = 1'b0;
    check("n_sec_sat", sec_count_2, 3);
    fifo_dout_valid_2 = 1'b1; fifo_sec_err_2 = 1'b1; err_clr_2 = 1'b1;
    cycle();
    fifo_dout_valid_2 = 1'b0; fifo_sec_err_2 = 1'b0; err_clr_2 = 1'b0;
    check("n_sec_clr_event", sec_count_2, 1);
    fifo_dout_valid_2 = 1'b1; fifo_sec_err_2 = 1'b1; fifo_ded_err_2 = 1'b1;
    fifo_dout_2 = 32'hDEAD_BEEF;
    cycle();
    fifo_dout_valid_2 = 1'b0; fifo_sec_err_2 = 1'b0; fifo_ded_err_2 = 1'b0;
    check("n_ded_fwd_valid", m_valid_2, 1);
    check("n_ded_fwd_data", m_data_2, 32'hDEAD_BEEF);
    check("n_ded_tags", {m_corrected_2, m_ded_2}, 2'b01);
    check("n_ded_counts", {sec_count_2, ded_count_2}, 4'b0101);
    check("n_err_irq", err_irq_2, 1);
    fifo_empty_2 = 1'b0;
    #1;
    check("n_no_halt_rd", fifo_rd_en_2, 1);
    fifo_empty_2 = 1'b1;
    #1;
    check("n_empty_no_rd", fifo_rd_en_2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_fifo_drain.md
ECC_FIFO_DRAIN -- requirements
Module: ecc_fifo_drain

Interface
REQ-001 Parameter DATA_W, 32, data width; matches the ECC FIFO payload width.
REQ-002 Parameter CNT_W, 16, width of the error counters.
REQ-003 Parameter DROP_DED, 1, 1 = discard DED words; 0 = forward them tagged with m_ded.
REQ-004 Parameter HALT_ON_DED, 1, 1 = stop popping after a DED until err_clr.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fifo_empty  input  1  upstream ECC FIFO empty flag.
REQ-008 fifo_rd_en  output  1  pop request to the ECC FIFO.
REQ-009 fifo_dout  input  DATA_W  corrected read data.
REQ-010 fifo_dout_valid  input  1  read data valid, exactly one cycle after the accepted fifo_rd_en.
REQ-011 fifo_sec_err / fifo_ded_err  input  1 each  error flags, qualified by fifo_dout_valid.
REQ-012 m_valid / m_ready  output / input  1 each  downstream valid/ready handshake.
REQ-013 m_data  output  DATA_W  output word.
REQ-014 m_corrected / m_ded  output  1 each  sideband tags: SEC corrected / uncorrectable (m_ded only when DROP_DED=0).
REQ-015 sec_count / ded_count  output  CNT_W each  saturating error counters.
REQ-016 err_irq  output  1  sticky flag, set on any DED.
REQ-017 err_clr  input  1  single-cycle pulse; clears counters, err_irq and HALTED.

Function
REQ-018 The block SHALL contain a 3-entry output buffer (data plus 2 tag bits), in order, with registered occupancy count cnt (0..3).
REQ-019 The block SHALL track inflight = registered copy of fifo_rd_en.
REQ-020 The block SHALL assert fifo_rd_en = !fifo_empty && state==RUN && (cnt + inflight) < 3, using registered terms only (no m_ready-to-fifo_rd_en path).
REQ-021 On fifo_dout_valid, the block SHALL write {fifo_dout, sec, ded} into the buffer, except a DED word when DROP_DED=1, which is discarded.
REQ-022 Latency SHALL be: fifo_rd_en at cycle t, fifo_dout_valid at t+1, m_valid at t+2 (buffer empty case).
REQ-023 m_valid SHALL be cnt!=0; the head entry SHALL drive m_data/m_corrected/m_ded and be popped on m_valid && m_ready.
REQ-024 On a simultaneous buffer write and pop, cnt SHALL be unchanged and order preserved.
REQ-025 Sustained throughput SHALL be one word per cycle when m_ready=1 and the FIFO is non-empty.
REQ-026 While m_valid && !m_ready, m_data and its tags SHALL be held stable.
REQ-027 sec_count SHALL increment on each valid SEC and ded_count on each valid DED (dropped or not); both SHALL saturate at all-ones.
REQ-028 When err_clr coincides with an error event, the affected counter SHALL load 1 and err_irq SHALL reflect the new event; otherwise err_clr SHALL load 0.
REQ-029 FSM states SHALL be RUN and HALTED: RUN->HALTED on a valid DED when HALT_ON_DED=1; HALTED->RUN on err_clr.
REQ-030 In HALTED, fifo_rd_en SHALL be 0, an in-flight word SHALL still be captured, and the buffer SHALL continue to drain.
REQ-031 fifo_rd_en SHALL never be asserted when fifo_empty=1.
REQ-032 If sec and ded are both set, the word SHALL be treated as DED only.

Reset
REQ-033 During and after rst: fifo_rd_en=0, m_valid=0, m_data=0, m_corrected=0, m_ded=0, counters=0, err_irq=0, cnt=0, inflight=0, state=RUN.
REQ-034 On reset mid-operation, the block SHALL discard any in-flight word and any buffered words, and SHALL not replay them.

Structure
REQ-035 Shared package ecc_fifo_pkg SHALL hold DATA_W default, the ECC code width (7), and the drain FSM state enum.
REQ-036 The 3-entry buffer SHALL be a sub-module, ecc_fifo_drain_buf, with write, pop, cnt and head outputs.

Verification
REQ-037 Write 1000,2000,3000,4000,5000 with m_ready=1 -> m_data 1000..5000 in order, no tags set, and 2 cycles from first fifo_rd_en to m_valid.
REQ-038 Inject a SEC on 2000 -> m_data=2000 with m_corrected=1, sec_count=1, err_irq=0.
REQ-039 DED on 4000, DROP_DED=1, HALT_ON_DED=1 -> 4000 absent, ded_count=1, err_irq=1, no fifo_rd_en until an err_clr pulse, then 5000 delivered.
REQ-040 Five words queued, m_ready=0 -> exactly 3 fifo_rd_en pulses, m_data holds 1000; release m_ready -> all five words delivered in order.
REQ-041 CNT_W=2, 5 SECs -> sec_count=3; err_clr in the same cycle as a SEC -> sec_count=1.
REQ-042 Assert rst while 2 words are buffered and 1 is in flight -> all outputs at reset values next cycle; normal popping resumes after rst is released.
